// File: rtl/herald_cmd_pkg.sv
// Shared command/error codes and FSM state encoding for the Herald host front end.
package herald_cmd_pkg;

    localparam logic [7:0] CMD_SINCOS    = 8'h10;
    localparam logic [7:0] CMD_ATAN2     = 8'h11;
    localparam logic [7:0] CMD_SQRT      = 8'h12;
    localparam logic [7:0] CMD_NORMALIZE = 8'h13;
    localparam logic [7:0] CMD_MUL       = 8'h20;
    localparam logic [7:0] CMD_MAC       = 8'h21;
    localparam logic [7:0] CMD_CLEAR     = 8'h22;
    localparam logic [7:0] CMD_MSU       = 8'h23;

    localparam logic [7:0] E_BADCMD  = 8'hE0;
    localparam logic [7:0] E_TIMEOUT = 8'hE1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_OPA,
        S_OPB,
        S_START,
        S_WAIT,
        S_READ,
        S_ERROR
    } state_t;

endpackage

// File: rtl/herald_cmd_decode.sv
// Combinational command decode: validity, operand count and result word count.
// Zero latency; no flow control.
module herald_cmd_decode
    import herald_cmd_pkg::*;
(
    input  logic [7:0] i_cmd,
    output logic       o_known,
    output logic [1:0] o_n_ops,
    output logic [1:0] o_res_words
);

    always_comb begin
        o_known     = 1'b1;
        o_n_ops     = 2'd2;
        o_res_words = 2'd1;
        case (i_cmd)
            CMD_SINCOS: begin
                o_n_ops     = 2'd1;
                o_res_words = 2'd2;
            end
            CMD_ATAN2, CMD_SQRT, CMD_MUL, CMD_MAC, CMD_MSU: begin
                o_n_ops     = 2'd2;
                o_res_words = 2'd1;
            end
            CMD_NORMALIZE: begin
                o_n_ops     = 2'd2;
                o_res_words = 2'd3;
            end
            CMD_CLEAR: begin
                o_n_ops     = 2'd0;
                o_res_words = 2'd0;
            end
            default: begin
                o_known     = 1'b0;
                o_n_ops     = 2'd0;
                o_res_words = 2'd0;
            end
        endcase
    end

endmodule

// File: rtl/herald_cmd_frontend.sv
// Byte-serial host front end: collects command + operands, runs a backend with watchdog, streams result bytes.
// Strobe edges act SYNC_STAGES+1 cycles after the pin rises; data_out lags byte_cnt by one cycle.
module herald_cmd_frontend
    import herald_cmd_pkg::*;
#(
    parameter int OP_W          = 24,
    parameter int RES_WORDS_MAX = 3,
    parameter int SYNC_STAGES   = 2,
    parameter int TIMEOUT       = 1024
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    input  logic                          wr_strobe,
    input  logic                          rd_strobe,
    output logic [7:0]                    data_out,
    output logic                          busy,
    output logic                          err,
    output logic [7:0]                    cmd,
    output logic [OP_W-1:0]               op_a,
    output logic [OP_W-1:0]               op_b,
    output logic                          exec_start,
    output logic                          exec_abort,
    input  logic                          exec_done,
    input  logic [RES_WORDS_MAX*OP_W-1:0] exec_result
);

    localparam int OP_BYTES      = OP_W / 8;
    localparam int RES_W         = RES_WORDS_MAX * OP_W;
    localparam int RES_BYTES_MAX = RES_W / 8;
    localparam int CW            = $clog2(RES_BYTES_MAX + 1);
    localparam int TW            = $clog2(TIMEOUT);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_wr_sync;
    logic [SYNC_STAGES-1:0] r_rd_sync;
    logic                   r_wr_prev;
    logic                   r_rd_prev;
    logic [7:0]             r_cmd;
    logic [OP_W-1:0]        r_op_a;
    logic [OP_W-1:0]        r_op_b;
    logic [RES_W-1:0]       r_result;
    logic [CW-1:0]          r_byte_cnt;
    logic [TW-1:0]          r_timer;
    logic [7:0]             r_err_code;
    logic [7:0]             r_data_out;

    logic                   w_wr_edge;
    logic                   w_rd_edge;
    logic [7:0]             w_dec_cmd;
    logic                   w_known;
    logic [1:0]             w_n_ops;
    logic [1:0]             w_res_words;
    logic [1:0]             w_res_words_c;
    logic [CW-1:0]          w_res_bytes;
    logic                   w_load_cmd;
    logic                   w_wr_a;
    logic                   w_wr_b;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_capture;
    logic                   w_timer_clr;
    logic                   w_set_err;
    logic [7:0]             w_err_code;
    logic                   w_exec_abort;

    assign w_wr_edge = r_wr_sync[SYNC_STAGES-1] & ~r_wr_prev;
    assign w_rd_edge = r_rd_sync[SYNC_STAGES-1] & ~r_rd_prev;

    // In IDLE the command byte is still on the bus, so decode it directly.
    assign w_dec_cmd = (r_state == S_IDLE) ? data_in : r_cmd;

    herald_cmd_decode u_decode (
        .i_cmd       (w_dec_cmd),
        .o_known     (w_known),
        .o_n_ops     (w_n_ops),
        .o_res_words (w_res_words)
    );

    always_comb begin
        w_res_words_c = w_res_words;
        if (int'(w_res_words) > RES_WORDS_MAX) begin
            w_res_words_c = 2'(RES_WORDS_MAX);
        end
        w_res_bytes = CW'(int'(w_res_words_c) * OP_BYTES);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_load_cmd   = 1'b0;
        w_wr_a       = 1'b0;
        w_wr_b       = 1'b0;
        w_cnt_clr    = 1'b0;
        w_cnt_inc    = 1'b0;
        w_capture    = 1'b0;
        w_timer_clr  = 1'b0;
        w_set_err    = 1'b0;
        w_err_code   = E_BADCMD;
        w_exec_abort = 1'b0;
        if ((r_state != S_IDLE) && w_wr_edge && w_rd_edge) begin
            w_state_nxt  = S_IDLE;
            w_exec_abort = (r_state == S_WAIT);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_wr_edge) begin
                        w_load_cmd = 1'b1;
                        w_cnt_clr  = 1'b1;
                        if (!w_known) begin
                            w_state_nxt = S_ERROR;
                            w_set_err   = 1'b1;
                            w_err_code  = E_BADCMD;
                        end else if (w_n_ops == 2'd0) begin
                            w_state_nxt = S_START;
                        end else begin
                            w_state_nxt = S_OPA;
                        end
                    end
                end
                S_OPA: begin
                    if (w_wr_edge) begin
                        w_wr_a = 1'b1;
                        if (r_byte_cnt == CW'(OP_BYTES - 1)) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = (w_n_ops == 2'd2) ? S_OPB : S_START;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_OPB: begin
                    if (w_wr_edge) begin
                        w_wr_b = 1'b1;
                        if (r_byte_cnt == CW'(OP_BYTES - 1)) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_START;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_START: begin
                    w_timer_clr = 1'b1;
                    w_state_nxt = S_WAIT;
                end
                S_WAIT: begin
                    // A done arriving on the last watchdog cycle still counts as success.
                    if (exec_done) begin
                        w_capture   = 1'b1;
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = (w_res_bytes == '0) ? S_IDLE : S_READ;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        w_state_nxt  = S_ERROR;
                        w_set_err    = 1'b1;
                        w_err_code   = E_TIMEOUT;
                        w_exec_abort = 1'b1;
                    end
                end
                S_READ: begin
                    if (w_rd_edge) begin
                        if (r_byte_cnt + CW'(1) == w_res_bytes) begin
                            w_cnt_clr   = 1'b1;
                            w_state_nxt = S_IDLE;
                        end else begin
                            w_cnt_inc = 1'b1;
                        end
                    end
                end
                S_ERROR: begin
                    if (w_rd_edge) begin
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_sync  <= '0;
            r_rd_sync  <= '0;
            r_wr_prev  <= 1'b0;
            r_rd_prev  <= 1'b0;
            r_cmd      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_result   <= '0;
            r_byte_cnt <= '0;
            r_timer    <= '0;
            r_err_code <= '0;
            r_data_out <= '0;
        end else begin
            r_wr_sync[0] <= wr_strobe;
            r_rd_sync[0] <= rd_strobe;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_wr_sync[i] <= r_wr_sync[i-1];
                r_rd_sync[i] <= r_rd_sync[i-1];
            end
            r_wr_prev <= r_wr_sync[SYNC_STAGES-1];
            r_rd_prev <= r_rd_sync[SYNC_STAGES-1];

            if (w_load_cmd) begin
                r_cmd <= data_in;
            end
            if (w_wr_a) begin
                r_op_a[{r_byte_cnt, 3'b000} +: 8] <= data_in;
            end
            if (w_wr_b) begin
                r_op_b[{r_byte_cnt, 3'b000} +: 8] <= data_in;
            end
            if (w_cnt_clr) begin
                r_byte_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_byte_cnt <= r_byte_cnt + CW'(1);
            end
            if (w_timer_clr) begin
                r_timer <= '0;
            end else if (r_state == S_WAIT) begin
                r_timer <= r_timer + TW'(1);
            end
            if (w_capture) begin
                r_result <= exec_result;
            end
            if (w_set_err) begin
                r_err_code <= w_err_code;
            end

            case (r_state)
                S_READ:  r_data_out <= r_result[{r_byte_cnt, 3'b000} +: 8];
                S_ERROR: r_data_out <= r_err_code;
                default: r_data_out <= '0;
            endcase
        end
    end

    assign data_out   = r_data_out;
    assign busy       = (r_state == S_OPA) || (r_state == S_OPB) ||
                        (r_state == S_START) || (r_state == S_WAIT);
    assign err        = (r_state == S_ERROR);
    assign cmd        = r_cmd;
    assign op_a       = r_op_a;
    assign op_b       = r_op_b;
    assign exec_start = (r_state == S_START);
    assign exec_abort = w_exec_abort;

endmodule

// File: doc/herald_cmd_frontend.md
Name: herald_cmd_frontend

Overview:
Parametrised byte-serial host front end for the Herald CORDIC/MAC accelerator. It replaces the fixed 24-bit command FSM with a generic one.
- Strobes are synchronised and edge-detected.
- A command byte plus 0–2 operands of OP_W bits are collected, LSB byte first.
- The selected backend is started with a start/done handshake and a watchdog.
- Results are streamed back byte-by-byte.
- Error reporting and host abort are included.

Parameters:
OP_W, 24, operand/result word width in bits; multiple of 8, 8..32
RES_WORDS_MAX, 3, max result words held (result buffer = RES_WORDS_MAX*OP_W bits)
SYNC_STAGES, 2, synchroniser flops on wr/rd strobes (>=1)
TIMEOUT, 1024, cycles in WAIT before watchdog error (>=2)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
data_in  in  8  host byte bus
wr_strobe  in  1  host write strobe (async level)
rd_strobe  in  1  host read strobe (async level)
data_out  out  8  result byte / error code
busy  out  1  high from command accept until result/error available
err  out  1  high while in ERROR
cmd  out  8  latched command code to backends
op_a  out  OP_W  operand A
op_b  out  OP_W  operand B
exec_start  out  1  one-cycle start pulse
exec_abort  out  1  one-cycle pulse on abort/timeout during WAIT
exec_done  in  1  backend completion; sampled only in WAIT
exec_result  in  RES_WORDS_MAX*OP_W  backend result, valid with exec_done

Behaviour:
Reset:
- Synchronous, active-low: every clk edge with rst_n=0 resets the block.
- State=IDLE; all outputs, counters, synchronisers, prev-strobe flops and buffers are 0.

Strobes:
- Each strobe passes through SYNC_STAGES flops.
- edge = synced & ~prev, so an edge is seen SYNC_STAGES+1 cycles after the pin rises.
- A held strobe produces exactly one edge.

Abort:
- wr_edge and rd_edge in the same cycle, in any state other than IDLE, return the block to IDLE.
- busy=0, err=0, data_out=0.
- exec_abort pulses if the abort occurs in WAIT. This has priority over all other transitions.

Decode (combinational, from cmd): known, n_ops (0..2), res_words (0..3). res_bytes = res_words*OP_W/8.

States and transitions:
- IDLE:
  - busy=0, data_out=0.
  - wr_edge: cmd<=data_in, byte_cnt<=0.
  - Unknown command -> ERROR, code 8'hE0.
  - n_ops=0 -> START.
  - Otherwise -> OPA.
- OPA / OPB:
  - busy=1.
  - Each wr_edge writes data_in into byte byte_cnt of op_a / op_b, LSB first.
  - After byte OP_W/8-1: OPA -> OPB if n_ops=2, else -> START. OPB -> START.
  - rd_edge is ignored.
- START:
  - exec_start=1 for exactly one cycle, timer<=0, -> WAIT.
- WAIT:
  - busy=1.
  - exec_done=1: capture exec_result. Then -> IDLE if res_bytes=0, else -> READ with byte_cnt=0.
  - timer==TIMEOUT-1 without done: -> ERROR, code 8'hE1, exec_abort pulse.
  - exec_done on the same cycle as the timeout wins.
  - wr_edge is ignored.
- READ:
  - busy=0.
  - data_out continuously presents result byte byte_cnt, registered and updated the cycle after byte_cnt changes.
  - rd_edge advances byte_cnt. Advancing past res_bytes-1 -> IDLE, data_out=0.
  - wr_edge is ignored.
- ERROR:
  - err=1, busy=0, data_out=error code.
  - rd_edge -> IDLE (err cleared).

Other rules:
- op_a/op_b hold their values until overwritten by the next command. Unused op_b is not cleared.
- exec_done outside WAIT is ignored.
- Result bytes beyond res_bytes are never emitted.

Decomposition:
- Package herald_cmd_pkg:
  - Command codes: SINCOS 8'h10, ATAN2 8'h11, SQRT 8'h12, NORMALIZE 8'h13, MUL 8'h20, MAC 8'h21, CLEAR 8'h22, MSU 8'h23.
  - Error codes: E_BADCMD 8'hE0, E_TIMEOUT 8'hE1.
  - State enum.
- Sub-module herald_cmd_decode: combinational cmd -> {known, n_ops, res_words}.
  - SINCOS 1/2, ATAN2 2/1, SQRT 2/1, NORMALIZE 2/3, MUL 2/1, MAC 2/1, MSU 2/1, CLEAR 0/0.

Test Plan:
1. OP_W=24. Write 8'h20, then A=01 00 00 and B=02 00 00. Backend returns done with result 24'h000003 after 5 cycles. Required: exactly one exec_start; op_a=24'h000001, op_b=24'h000002; busy falls when done; three reads give 03, 00, 00; then IDLE with data_out=0.
2. Write 8'h13 with two operands. Result 72'h0908_0706_0504_0302_01 returned. Required: nine reads give 01..09 in order; the tenth rd_edge is ignored in IDLE.
3. Write 8'h22. Required: exec_start with no operand bytes; done -> IDLE directly; no READ, busy=0.
4. Write 8'h55. Required: err=1, data_out=8'hE0, exec_start never pulses; one read -> IDLE, err=0.
5. TIMEOUT=16. Write 8'h10 plus 3 bytes, with exec_done held low. Required: exactly 16 cycles after exec_start, ERROR with data_out=8'hE1 and a one-cycle exec_abort.
6. Raise wr_strobe and rd_strobe together mid-OPB. Required: IDLE next cycle, busy=0. Also assert rst_n=0 for one cycle in WAIT: all outputs are 0 on the next edge, and a late exec_done is ignored.
